// File: rtl/race_state_fsm_pkg.sv
// Shared race encodings and zone helper for the race sequencer and its lap trackers.
// State values match race_defs.vh used by OperationEncoder and PhysicsEngine.
package race_state_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd2,
        ST_RACING    = 3'd4,
        ST_FINISH    = 3'd5
    } race_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] CD_START = 2'd3;

    function automatic logic in_box(input logic [9:0] x, input logic [9:0] y,
                                    input logic [9:0] x0, input logic [9:0] x1,
                                    input logic [9:0] y0, input logic [9:0] y1);
        return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
    endfunction

endpackage

// File: rtl/race_state_fsm_if.sv
// Input/output bundle between the race sequencer and its environment.
// slave is the sequencer side, master the driving side.
interface race_state_fsm_if;
    logic        i_frame_tick;
    logic        i_start_pulse;
    logic [9:0]  i_p1_x;
    logic [9:0]  i_p1_y;
    logic [9:0]  i_p2_x;
    logic [9:0]  i_p2_y;
    logic [2:0]  o_race_state;
    logic [1:0]  o_countdown;
    logic [2:0]  o_p1_lap;
    logic [2:0]  o_p2_lap;
    logic [1:0]  o_winner;
    logic [15:0] o_race_frames;

    modport master (
        output i_frame_tick, i_start_pulse, i_p1_x, i_p1_y, i_p2_x, i_p2_y,
        input  o_race_state, o_countdown, o_p1_lap, o_p2_lap, o_winner, o_race_frames
    );

    modport slave (
        input  i_frame_tick, i_start_pulse, i_p1_x, i_p1_y, i_p2_x, i_p2_y,
        output o_race_state, o_countdown, o_p1_lap, o_p2_lap, o_winner, o_race_frames
    );
endinterface

// File: rtl/race_state_fsm_lap_tracker.sv
// Per-kart lap counter: a lap counts only on a rising entry into the finish zone
// after the checkpoint has been visited. o_done is combinational so the FSM finishes on the same edge.
module lap_tracker
    import race_state_fsm_pkg::*;
#(
    parameter int LAPS_TO_WIN = 3,
    parameter int FIN_X0 = 0,   parameter int FIN_X1 = 60,
    parameter int FIN_Y0 = 118, parameter int FIN_Y1 = 121,
    parameter int CHK_X0 = 260, parameter int CHK_X1 = 319,
    parameter int CHK_Y0 = 100, parameter int CHK_Y1 = 140
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    output logic [2:0] o_lap,
    output logic       o_done
);
    logic       r_armed;
    logic       r_prev_fin;
    logic [2:0] r_lap;
    logic       w_in_fin;
    logic       w_in_chk;
    logic       w_event;

    assign w_in_fin = in_box(i_x, i_y, 10'(FIN_X0), 10'(FIN_X1), 10'(FIN_Y0), 10'(FIN_Y1));
    assign w_in_chk = in_box(i_x, i_y, 10'(CHK_X0), 10'(CHK_X1), 10'(CHK_Y0), 10'(CHK_Y1));

    // The lap-limit guard keeps the counter from ever passing LAPS_TO_WIN.
    assign w_event = i_enable && w_in_fin && !r_prev_fin && r_armed && (r_lap < 3'(LAPS_TO_WIN));
    assign o_done  = w_event && (r_lap == 3'(LAPS_TO_WIN - 1));
    assign o_lap   = r_lap;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_armed    <= 1'b0;
            r_prev_fin <= 1'b0;
            r_lap      <= 3'd0;
        end else if (i_clear) begin
            r_armed    <= 1'b0;
            r_prev_fin <= 1'b0;
            r_lap      <= 3'd0;
        end else if (i_enable) begin
            r_prev_fin <= w_in_fin;
            if (w_event) begin
                r_lap   <= r_lap + 3'd1;
                r_armed <= 1'b0;
            end else if (w_in_chk) begin
                r_armed <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/race_state_fsm.sv
// Race sequencer: countdown, per-kart lap tracking and winner declaration.
// Define RACE_TIMER_EN to build the race_frames counter; otherwise it is tied to zero.
module race_state_fsm
    import race_state_fsm_pkg::*;
#(
    parameter int LAPS_TO_WIN  = 3,
    parameter int COUNT_FRAMES = 60,
    parameter int FIN_X0 = 0,   parameter int FIN_X1 = 60,
    parameter int FIN_Y0 = 118, parameter int FIN_Y1 = 121,
    parameter int CHK_X0 = 260, parameter int CHK_X1 = 319,
    parameter int CHK_Y0 = 100, parameter int CHK_Y1 = 140
) (
    input  logic              i_clk,
    input  logic              i_rst,
    race_state_fsm_if.slave   bus
);
    localparam int NUM_KARTS = 2;
    localparam int CNT_W     = $clog2(COUNT_FRAMES + 1);

    race_state_t        r_state, w_nxt_state;
    logic [1:0]         r_cd, w_nxt_cd;
    logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
    logic [1:0]         r_win, w_nxt_win;
    logic               w_clear;
    logic               w_enable;

    logic [NUM_KARTS-1:0][9:0] w_x;
    logic [NUM_KARTS-1:0][9:0] w_y;
    logic [NUM_KARTS-1:0][2:0] w_lap;
    logic [NUM_KARTS-1:0]      w_done;

    assign w_x = {bus.i_p2_x, bus.i_p1_x};
    assign w_y = {bus.i_p2_y, bus.i_p1_y};
    assign w_enable = (r_state == ST_RACING);

    for (genvar k = 0; k < NUM_KARTS; k++) begin : g_kart
        lap_tracker #(
            .LAPS_TO_WIN(LAPS_TO_WIN),
            .FIN_X0(FIN_X0), .FIN_X1(FIN_X1), .FIN_Y0(FIN_Y0), .FIN_Y1(FIN_Y1),
            .CHK_X0(CHK_X0), .CHK_X1(CHK_X1), .CHK_Y0(CHK_Y0), .CHK_Y1(CHK_Y1)
        ) u_lap (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_clear  (w_clear),
            .i_enable (w_enable),
            .i_x      (w_x[k]),
            .i_y      (w_y[k]),
            .o_lap    (w_lap[k]),
            .o_done   (w_done[k])
        );
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cd    = r_cd;
        w_nxt_cnt   = r_cnt;
        w_nxt_win   = r_win;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start_pulse) begin
                    w_nxt_state = ST_COUNTDOWN;
                    w_nxt_cd    = CD_START;
                    w_nxt_cnt   = '0;
                    w_nxt_win   = WIN_NONE;
                    w_clear     = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                if (bus.i_frame_tick) begin
                    if (r_cnt == CNT_W'(COUNT_FRAMES - 1)) begin
                        w_nxt_cnt = '0;
                        if (r_cd == 2'd1) begin
                            w_nxt_state = ST_RACING;
                            w_nxt_cd    = 2'd0;
                        end else begin
                            w_nxt_cd = r_cd - 2'd1;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_RACING: begin
                // Bit 0 is P1, bit 1 is P2, so a same-clk finish yields the draw code 11.
                if (|w_done) begin
                    w_nxt_state = ST_FINISH;
                    w_nxt_win   = w_done;
                end
            end
            ST_FINISH: begin
                if (bus.i_start_pulse) w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cd    = 2'd0;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cd    <= 2'd0;
            r_cnt   <= '0;
            r_win   <= WIN_NONE;
        end else begin
            r_state <= w_nxt_state;
            r_cd    <= w_nxt_cd;
            r_cnt   <= w_nxt_cnt;
            r_win   <= w_nxt_win;
        end
    end

`ifdef RACE_TIMER_EN
    logic [15:0] r_race_frames;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_race_frames <= 16'h0000;
        end else if (w_clear) begin
            r_race_frames <= 16'h0000;
        end else if (w_enable && bus.i_frame_tick && (r_race_frames != 16'hFFFF)) begin
            r_race_frames <= r_race_frames + 16'd1;
        end
    end

    assign bus.o_race_frames = r_race_frames;
`else
    assign bus.o_race_frames = 16'h0000;
`endif

    assign bus.o_race_state = r_state;
    assign bus.o_countdown  = r_cd;
    assign bus.o_p1_lap     = w_lap[0];
    assign bus.o_p2_lap     = w_lap[1];
    assign bus.o_winner     = r_win;
endmodule
